// File: rtl/ctrl_pipe_hazard_pkg.sv
// rtl/ctrl_pipe_hazard_pkg.sv - shared decoder control bundle definitions
// Field widths, opcodes and bundle bit positions common to decoder and pipeline.
package riscv_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 3;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_SRC    = ALU_OP_WIDTH;
  localparam int CTRL_REG_WRITE  = ALU_OP_WIDTH + 1;
  localparam int CTRL_MEM_WRITE  = ALU_OP_WIDTH + 2;
  localparam int CTRL_MEM_TO_REG = ALU_OP_WIDTH + 3;
  localparam int CTRL_MEM_READ   = ALU_OP_WIDTH + 4;
  localparam int CTRL_BRANCH     = ALU_OP_WIDTH + 5;
  localparam int CTRL_W          = ALU_OP_WIDTH + 6;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t pack_ctrl(
    input logic                    branch,
    input logic                    mem_read,
    input logic                    mem_to_reg,
    input logic                    mem_write,
    input logic                    alu_src,
    input logic                    reg_write,
    input logic [ALU_OP_WIDTH-1:0] alu_op
  );
    ctrl_t c;
    c                                       = CTRL_BUBBLE;
    c[CTRL_BRANCH]                          = branch;
    c[CTRL_MEM_READ]                        = mem_read;
    c[CTRL_MEM_TO_REG]                      = mem_to_reg;
    c[CTRL_MEM_WRITE]                       = mem_write;
    c[CTRL_ALU_SRC]                         = alu_src;
    c[CTRL_REG_WRITE]                       = reg_write;
    c[CTRL_ALU_OP_LSB +: ALU_OP_WIDTH]      = alu_op;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// rtl/ctrl_pipe_hazard_if.sv - decoder bundle in, per-stage controls out
// The master side is the ID-stage decoder/datapath; the slave side is the pipeline.
interface ctrl_pipe_hazard_if #(
  parameter int REG_ADDR_W = riscv_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int ALU_OP_W   = riscv_ctrl_pkg::ALU_OP_WIDTH
);

  logic                  Branch_i;
  logic                  Mem_Read_i;
  logic                  Mem_to_Reg_i;
  logic                  Mem_Write_i;
  logic                  ALU_Src_i;
  logic                  Reg_Write_i;
  logic [ALU_OP_W-1:0]   ALU_Op_i;
  logic [REG_ADDR_W-1:0] Rs1_i;
  logic [REG_ADDR_W-1:0] Rs2_i;
  logic [REG_ADDR_W-1:0] Rd_i;
  logic                  Flush_i;

  logic                  Stall_o;
  logic                  Branch_EX_o;
  logic                  ALU_Src_EX_o;
  logic [ALU_OP_W-1:0]   ALU_Op_EX_o;
  logic [REG_ADDR_W-1:0] Rd_EX_o;
  logic                  Mem_Read_MEM_o;
  logic                  Mem_Write_MEM_o;
  logic                  Reg_Write_MEM_o;
  logic [REG_ADDR_W-1:0] Rd_MEM_o;
  logic                  Mem_to_Reg_WB_o;
  logic                  Reg_Write_WB_o;
  logic [REG_ADDR_W-1:0] Rd_WB_o;

  modport master (
    output Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i,
           ALU_Op_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    input  Stall_o, Branch_EX_o, ALU_Src_EX_o, ALU_Op_EX_o, Rd_EX_o,
           Mem_Read_MEM_o, Mem_Write_MEM_o, Reg_Write_MEM_o, Rd_MEM_o,
           Mem_to_Reg_WB_o, Reg_Write_WB_o, Rd_WB_o
  );

  modport slave (
    input  Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i,
           ALU_Op_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    output Stall_o, Branch_EX_o, ALU_Src_EX_o, ALU_Op_EX_o, Rd_EX_o,
           Mem_Read_MEM_o, Mem_Write_MEM_o, Reg_Write_MEM_o, Rd_MEM_o,
           Mem_to_Reg_WB_o, Reg_Write_WB_o, Rd_WB_o
  );

endinterface

// File: rtl/ctrl_pipe_hazard_stage_reg.sv
// rtl/ctrl_pipe_hazard_stage_reg.sv - pipeline stage flop bank
// Synchronous reset and a clear input both load an all-zero bubble.
module ctrl_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d_i;
    if (clear_i) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall
// Stall_o is the only combinational output; every stage output comes from a flop.
module ctrl_pipe_hazard
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_WIDTH,
  parameter int ALU_OP_W   = ALU_OP_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_pipe_hazard_if.slave  bus
);

  localparam int IDEX_W  = CTRL_W + REG_ADDR_W;
  localparam int EXMEM_W = 4 + REG_ADDR_W;
  localparam int MEMWB_W = 2 + REG_ADDR_W;

  ctrl_t                 id_ctrl;
  logic [IDEX_W-1:0]     idex_d;
  logic [IDEX_W-1:0]     idex_q;
  ctrl_t                 ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;

  logic [EXMEM_W-1:0]    exmem_d;
  logic [EXMEM_W-1:0]    exmem_q;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  mem_reg_write;
  logic                  mem_mem_to_reg;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic [MEMWB_W-1:0]    memwb_d;
  logic [MEMWB_W-1:0]    memwb_q;
  logic                  wb_mem_to_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic                  hazard;
  logic                  stall;
  logic                  idex_clear;

  assign id_ctrl = pack_ctrl(bus.Branch_i, bus.Mem_Read_i, bus.Mem_to_Reg_i,
                             bus.Mem_Write_i, bus.ALU_Src_i, bus.Reg_Write_i,
                             bus.ALU_Op_i);
  assign idex_d  = {id_ctrl, bus.Rd_i};
  assign {ex_ctrl, ex_rd} = idex_q;

  // Rs2 is compared even when the ID instruction has no rs2; a spurious stall costs one cycle only.
  assign hazard = ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) &&
                  ((ex_rd == bus.Rs1_i) || (ex_rd == bus.Rs2_i));
  assign stall      = hazard && !bus.Flush_i;
  assign idex_clear = bus.Flush_i || stall;

  ctrl_stage_reg #(.WIDTH(IDEX_W)) u_id_ex (
    .clk     (clk),
    .reset   (reset),
    .clear_i (idex_clear),
    .d_i     (idex_d),
    .q_o     (idex_q)
  );

  assign exmem_d = {ex_ctrl[CTRL_MEM_READ], ex_ctrl[CTRL_MEM_WRITE],
                    ex_ctrl[CTRL_REG_WRITE], ex_ctrl[CTRL_MEM_TO_REG], ex_rd};

  ctrl_stage_reg #(.WIDTH(EXMEM_W)) u_ex_mem (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .d_i     (exmem_d),
    .q_o     (exmem_q)
  );

  assign {mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_rd} = exmem_q;
  assign memwb_d = {mem_mem_to_reg, mem_reg_write, mem_rd};

  ctrl_stage_reg #(.WIDTH(MEMWB_W)) u_mem_wb (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .d_i     (memwb_d),
    .q_o     (memwb_q)
  );

  assign {wb_mem_to_reg, wb_reg_write, wb_rd} = memwb_q;

  assign bus.Stall_o         = stall;
  assign bus.Branch_EX_o     = ex_ctrl[CTRL_BRANCH];
  assign bus.ALU_Src_EX_o    = ex_ctrl[CTRL_ALU_SRC];
  assign bus.ALU_Op_EX_o     = ex_ctrl[CTRL_ALU_OP_LSB +: ALU_OP_W];
  assign bus.Rd_EX_o         = ex_rd;
  assign bus.Mem_Read_MEM_o  = mem_mem_read;
  assign bus.Mem_Write_MEM_o = mem_mem_write;
  assign bus.Reg_Write_MEM_o = mem_reg_write;
  assign bus.Rd_MEM_o        = mem_rd;
  assign bus.Mem_to_Reg_WB_o = wb_mem_to_reg;
  assign bus.Reg_Write_WB_o  = wb_reg_write;
  assign bus.Rd_WB_o         = wb_rd;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - scoreboard bench for ctrl_pipe_hazard
// Stimulus queues hand-computed per-cycle outputs; a negedge monitor pops and compares.
module tb_ctrl_pipe_hazard;

  typedef struct {
    string       name;
    logic [25:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] r;
  logic [25:0] act;

  always #5 clk = ~clk;

  ctrl_pipe_hazard_if bus ();

  ctrl_pipe_hazard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign act = {bus.Stall_o,
                bus.Branch_EX_o, bus.ALU_Src_EX_o, bus.ALU_Op_EX_o, bus.Rd_EX_o,
                bus.Mem_Read_MEM_o, bus.Mem_Write_MEM_o, bus.Reg_Write_MEM_o, bus.Rd_MEM_o,
                bus.Mem_to_Reg_WB_o, bus.Reg_Write_WB_o, bus.Rd_WB_o};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: actual %h required %h", e.name, act, e.v);
      end
    end
  end

  task automatic set_id(input logic br, input logic mr, input logic m2r, input logic mw,
                        input logic src, input logic rw, input logic [2:0] op,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic flush);
    bus.Branch_i     = br;
    bus.Mem_Read_i   = mr;
    bus.Mem_to_Reg_i = m2r;
    bus.Mem_Write_i  = mw;
    bus.ALU_Src_i    = src;
    bus.Reg_Write_i  = rw;
    bus.ALU_Op_i     = op;
    bus.Rs1_i        = rs1;
    bus.Rs2_i        = rs2;
    bus.Rd_i         = rd;
    bus.Flush_i      = flush;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(0, 1, 1, 0, 1, 1, 3'b000, rs1, 5'd0, rd, 0);
  endtask

  task automatic rtype(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic flush);
    set_id(0, 0, 0, 0, 0, 1, op, rs1, rs2, rd, flush);
  endtask

  task automatic store(input logic [4:0] rs1, input logic [4:0] rs2, input logic flush);
    set_id(0, 0, 0, 1, 1, 0, 3'b000, rs1, rs2, 5'd0, flush);
  endtask

  task automatic expect_out(input string name, input logic st,
                            input logic bex, input logic sex, input logic [2:0] opx,
                            input logic [4:0] rdx,
                            input logic mrm, input logic mwm, input logic rwm,
                            input logic [4:0] rdm,
                            input logic m2w, input logic rww, input logic [4:0] rdw);
    exp_t e;
    e.name = name;
    e.v    = {st, bex, sex, opx, rdx, mrm, mwm, rwm, rdm, m2w, rww, rdw};
    exp_q.push_back(e);
  endtask

  task automatic zeros(input string name);
    expect_out(name, 0, 0, 0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    r = $urandom;
    set_id(r[0], r[1], r[2], r[3], r[4], r[5], r[8:6], r[13:9], r[18:14], r[23:19], r[24]);
    tick();
    r = $urandom;
    set_id(r[0], r[1], r[2], r[3], r[4], r[5], r[8:6], r[13:9], r[18:14], r[23:19], r[24]);
    zeros("reset_state");
    tick();
    reset = 1'b0;

    rtype(3'b000, 5'd1, 5'd2, 5'd5, 0);  zeros("rtype_issue"); tick();
    idle(); expect_out("rtype_ex",  0, 0, 0, 3'b000, 5'd5, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    idle(); expect_out("rtype_mem", 0, 0, 0, 3'b000, 5'd0, 0, 0, 1, 5'd5, 0, 0, 5'd0); tick();
    idle(); expect_out("rtype_wb",  0, 0, 0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'd5); tick();

    load(5'd7, 5'd2); zeros("load_issue"); tick();
    rtype(3'b010, 5'd7, 5'd9, 5'd8, 0);
    expect_out("load_use_stall", 1, 0, 1, 3'b000, 5'd7, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    expect_out("stall_bubble",   0, 0, 0, 3'b000, 5'd0, 1, 0, 1, 5'd7, 0, 0, 5'd0); tick();
    idle(); expect_out("add_late_ex", 0, 0, 0, 3'b010, 5'd8, 0, 0, 0, 5'd0, 1, 1, 5'd7); tick();
    idle(); expect_out("add_mem",     0, 0, 0, 3'b000, 5'd0, 0, 0, 1, 5'd8, 0, 0, 5'd0); tick();

    load(5'd0, 5'd4);
    expect_out("x0_load_issue", 0, 0, 0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'd8); tick();
    rtype(3'b010, 5'd0, 5'd0, 5'd6, 0);
    expect_out("x0_no_stall",   0, 0, 1, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    idle(); expect_out("x0_rw_mem", 0, 0, 0, 3'b010, 5'd6, 1, 0, 1, 5'd0, 0, 0, 5'd0); tick();
    idle(); expect_out("x0_rw_wb",  0, 0, 0, 3'b000, 5'd0, 0, 0, 1, 5'd6, 1, 1, 5'd0); tick();

    load(5'd3, 5'd1);
    expect_out("flush_load_issue", 0, 0, 0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'd6); tick();
    rtype(3'b010, 5'd1, 5'd3, 5'd4, 1);
    expect_out("flush_wins",   0, 0, 1, 3'b000, 5'd3, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    idle(); expect_out("flush_bubble", 0, 0, 0, 3'b000, 5'd0, 1, 0, 1, 5'd3, 0, 0, 5'd0); tick();
    idle(); expect_out("flush_drain",  0, 0, 0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 1, 1, 5'd3); tick();

    store(5'd2, 5'd5, 1); zeros("store_flush_issue"); tick();
    idle(); zeros("store_flush_ex");  tick();
    idle(); zeros("store_flush_mem"); tick();

    store(5'd2, 5'd5, 0); zeros("store_issue"); tick();
    set_id(1, 0, 0, 0, 0, 0, 3'b001, 5'd3, 5'd4, 5'd0, 0);
    expect_out("store_ex",  0, 0, 1, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    idle(); expect_out("branch_ex", 0, 1, 0, 3'b001, 5'd0, 0, 1, 0, 5'd0, 0, 0, 5'd0); tick();

    load(5'd9, 5'd1); zeros("rs2_load_issue"); tick();
    rtype(3'b010, 5'd1, 5'd9, 5'd10, 0);
    expect_out("rs2_stall",  1, 0, 1, 3'b000, 5'd9, 0, 0, 0, 5'd0, 0, 0, 5'd0); tick();
    expect_out("rs2_bubble", 0, 0, 0, 3'b000, 5'd0, 1, 0, 1, 5'd9, 0, 0, 5'd0); tick();
    rtype(3'b011, 5'd0, 5'd0, 5'd11, 0);
    reset = 1'b1;
    expect_out("pre_reset",  0, 0, 0, 3'b010, 5'd10, 0, 0, 0, 5'd0, 1, 1, 5'd9); tick();
    reset = 1'b0;
    idle(); zeros("mid_reset");  tick();
    idle(); zeros("post_reset"); tick();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending required 0 pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
